// File: rtl/seq_add_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package seq_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of digit steps needed to cover the operand width.
  function automatic int calc_ndig(input int width, input int digit);
    return (digit < 1) ? 1 : (width / digit);
  endfunction

  // Digit counter width; never narrower than one bit.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/seq_add_digit_add.sv
// DIGIT-wide ripple-carry adder used once per cycle by the serial datapath.
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             c
);

  // Ripple the carry from the low bit upward.
  always_comb begin
    logic carry;
    carry = cin;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    c = carry;
  end

endmodule

// File: rtl/seq_add.sv
// Digit-serial adder: a + b + cin over WIDTH bits, DIGIT bits per cycle,
// with valid/ready on both sides and a result register held until consumed.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for operands
// ST_RUN  | adding one digit per cycle, LSB digit first
// ST_DONE | out_valid=1, result held until out_ready
module seq_add
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_add: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic [WIDTH-1:0] acc_shift;

  digit_add #(.DIGIT(DIGIT)) u_digit_add (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_q[DIGIT-1:0]),
    .cin (carry_q),
    .s   (dig_s),
    .c   (dig_c)
  );

  // New digit enters at the top; after NDIG steps the sum is fully aligned.
  assign acc_shift = WIDTH'({dig_s, acc_q} >> DIGIT);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_shift;
        carry_d = dig_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // Low digit of a_q/b_q now holds the operand MSBs.
          s_d     = acc_shift;
          cout_d  = dig_c;
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dig_s[DIGIT-1] != a_q[DIGIT-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_add.sv
// Directed bench for seq_add in 16/4, 4/4 and 8/1 configurations.
module tb_seq_add;

  logic clk;
  logic rst_n;

  logic        x_in_valid, x_in_ready, x_cin, x_out_valid, x_out_ready, x_cout, x_ovf;
  logic [15:0] x_a, x_b, x_s;
  logic        y_in_valid, y_in_ready, y_cin, y_out_valid, y_out_ready, y_cout, y_ovf;
  logic [3:0]  y_a, y_b, y_s;
  logic        z_in_valid, z_in_ready, z_cin, z_out_valid, z_out_ready, z_cout, z_ovf;
  logic [7:0]  z_a, z_b, z_s;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  seq_add #(.WIDTH(16), .DIGIT(4)) u_x (
    .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
    .a(x_a), .b(x_b), .cin(x_cin), .out_valid(x_out_valid), .out_ready(x_out_ready),
    .s(x_s), .cout(x_cout), .ovf(x_ovf)
  );

  seq_add #(.WIDTH(4), .DIGIT(4)) u_y (
    .clk(clk), .rst_n(rst_n), .in_valid(y_in_valid), .in_ready(y_in_ready),
    .a(y_a), .b(y_b), .cin(y_cin), .out_valid(y_out_valid), .out_ready(y_out_ready),
    .s(y_s), .cout(y_cout), .ovf(y_ovf)
  );

  seq_add #(.WIDTH(8), .DIGIT(1)) u_z (
    .clk(clk), .rst_n(rst_n), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .a(z_a), .b(z_b), .cin(z_cin), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .s(z_s), .cout(z_cout), .ovf(z_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic x_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic [15:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    chk({tag, ".in_ready"}, 32'(x_in_ready), 1);
    x_a = a; x_b = b; x_cin = ci; x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0;
    lat = 0;
    while (x_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, ".latency"}, lat, 4);
    chk({tag, ".s"}, 32'(x_s), 32'(es));
    chk({tag, ".cout"}, 32'(x_cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(x_ovf), 32'(eo));
    x_out_ready = 1'b1;
    @(negedge clk);
    x_out_ready = 1'b0;
    chk({tag, ".idle"}, 32'({x_in_ready, x_out_valid}), 2);
  endtask

  task automatic y_op(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] es, input logic ec, input logic eo, input string tag);
    int lat;
    y_a = a; y_b = b; y_cin = ci; y_in_valid = 1'b1;
    @(negedge clk);
    y_in_valid = 1'b0;
    lat = 0;
    while (y_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, ".latency"}, lat, 1);
    chk({tag, ".s"}, 32'(y_s), 32'(es));
    chk({tag, ".cout"}, 32'(y_cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(y_ovf), 32'(eo));
    y_out_ready = 1'b1;
    @(negedge clk);
    y_out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int gap;
    rst_n = 1'b0;
    x_in_valid = 0; x_cin = 0; x_out_ready = 0; x_a = '0; x_b = '0;
    y_in_valid = 0; y_cin = 0; y_out_ready = 0; y_a = '0; y_b = '0;
    z_in_valid = 0; z_cin = 0; z_out_ready = 0; z_a = '0; z_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst.x_ready_valid", 32'({x_in_ready, x_out_valid}), 2);
    chk("rst.x_s_cout_ovf", 32'({x_s, x_cout, x_ovf}), 0);
    chk("rst.y_ready_valid", 32'({y_in_ready, y_out_valid}), 2);
    chk("rst.z_ready_valid", 32'({z_in_ready, z_out_valid}), 2);

    x_op(16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0, "x_1p2p1");
    x_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "x_carry");
    x_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "x_ovf");

    // Backpressure with a competing request while DONE is held
    x_a = 16'h5005; x_b = 16'h6006; x_cin = 1'b0; x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0;
    lat = 0;
    while (x_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("bp.latency", lat, 4);
    chk("bp.s", 32'(x_s), 32'hB00B);
    chk("bp.ovf", 32'(x_ovf), 1);
    for (int i = 0; i < 3; i++) begin
      x_a = 16'h1111; x_b = 16'h1111; x_in_valid = 1'b1;
      @(negedge clk);
      chk("bp.hold_s", 32'(x_s), 32'hB00B);
      chk("bp.hold_ready_valid", 32'({x_in_ready, x_out_valid}), 1);
    end
    x_in_valid = 1'b0;
    x_out_ready = 1'b1;
    @(negedge clk);
    x_out_ready = 1'b0;
    chk("bp.release", 32'({x_in_ready, x_out_valid}), 2);
    chk("bp.s_retained", 32'(x_s), 32'hB00B);
    repeat (6) @(negedge clk);
    chk("bp.no_stale_op", 32'(x_out_valid), 0);

    // Reset on the second RUN cycle
    x_a = 16'h1234; x_b = 16'h1111; x_cin = 1'b0; x_in_valid = 1'b1;
    @(negedge clk);
    x_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_run.ready_valid", 32'({x_in_ready, x_out_valid}), 2);
    chk("rst_run.s_cout_ovf", 32'({x_s, x_cout, x_ovf}), 0);
    repeat (6) @(negedge clk);
    chk("rst_run.no_output", 32'(x_out_valid), 0);
    x_op(16'h0005, 16'h000E, 1'b0, 16'h0013, 1'b0, 1'b0, "x_after_rst");

    // Single-digit configuration
    y_op(4'h1, 4'h2, 1'b1, 4'h4, 1'b0, 1'b0, "y_1p2p1");
    y_op(4'h5, 4'h6, 1'b0, 4'hB, 1'b0, 1'b1, "y_5p6");
    y_op(4'h9, 4'hA, 1'b1, 4'h4, 1'b1, 1'b1, "y_9pAp1");
    y_op(4'h5, 4'hE, 1'b0, 4'h3, 1'b1, 1'b0, "y_5pE");

    // Bit-serial configuration
    z_a = 8'h80; z_b = 8'h80; z_cin = 1'b0; z_in_valid = 1'b1;
    @(negedge clk);
    z_in_valid = 1'b0;
    lat = 0;
    while (z_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("z_80p80.latency", lat, 8);
    chk("z_80p80.s", 32'(z_s), 0);
    chk("z_80p80.cout_ovf", 32'({z_cout, z_ovf}), 3);
    z_out_ready = 1'b1;
    @(negedge clk);
    chk("z_80p80.idle", 32'({z_in_ready, z_out_valid}), 2);

    // Back-to-back with out_ready tied high: one result per NDIG+2 cycles
    z_a = 8'h03; z_b = 8'h04; z_cin = 1'b1; z_in_valid = 1'b1;
    lat = 0;
    while (z_out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    chk("z_b2b.first_s", 32'(z_s), 32'h08);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (z_out_valid !== 1'b1 && gap < 40);
    chk("z_b2b.interval", gap, 10);
    chk("z_b2b.second_s", 32'(z_s), 32'h08);
    z_in_valid = 1'b0;
    z_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_add.md
Name: seq_add

Overview:
- Parametrised, multi-cycle, digit-serial adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per cycle.
- Valid/ready handshake on both sides; result registered and held until consumed.
- Successor to the fixed 4-bit combinational adder; trades latency for adder area at wide WIDTH.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits added per cycle, 1..WIDTH; DIGIT=WIDTH gives single-cycle operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands a/b/cin valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  s/cout/ovf valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum, (a+b+cin) mod 2^WIDTH.
- cout  out  1  unsigned carry-out.
- ovf  out  1  two's-complement overflow: a[MSB]==b[MSB] and s[MSB]!=a[MSB].

Behaviour:
- NDIG = WIDTH/DIGIT. Elaboration error if WIDTH%DIGIT!=0 or DIGIT<1.
- Reset (rst_n=0 at posedge): state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, digit count=0, internal carry=0.
- Reset applies in every state; any in-flight operation is discarded without output.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b, cin into shift registers, clear count, go to RUN.
  - RUN: in_ready=0. Each cycle: add low DIGIT bits of A/B shift regs with carry reg, shift the DIGIT-bit sum into the top of S shift reg, shift A/B right by DIGIT, update carry, count++. On the cycle processing digit NDIG-1: capture cout=carry out, ovf from MSBs, go to DONE.
  - DONE: out_valid=1; s/cout/ovf stable. On out_ready go to IDLE.
- Latency:
  - Handshake at edge k → out_valid high after edge k+NDIG (16/4: 4 cycles; DIGIT=WIDTH: 1 cycle).
  - Throughput: one result per NDIG+2 cycles minimum.
- No bypass: in_ready is 0 in RUN and DONE. in_valid and operand changes are ignored outside IDLE.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- out_ready while out_valid=0 has no effect.
- s/cout/ovf keep their last value after return to IDLE, until the next DONE overwrites them.
- All outputs are registered; no combinational path from inputs to outputs.
- Signed/unsigned: arithmetic is identical; cout is the unsigned flag, ovf the signed flag.

Decomposition:
- Package seq_add_pkg: state enum (IDLE, RUN, DONE), function computing NDIG, count width clog2(NDIG) (min 1).
- Sub-module digit_add: combinational DIGIT-wide ripple adder with a, b, cin, s, c. Instantiated once inside seq_add.

Test Plan:
- WIDTH=16, DIGIT=4: a=0x0001, b=0x0002, cin=1 → s=0x0004, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 → s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 → s=0x8000, cout=0, ovf=1.
- Backpressure: a=0x5005, b=0x6006, cin=0. Hold out_ready=0 for 3 cycles after out_valid → s=0xB00B held stable, in_ready=0 throughout. A new in_valid pulse during that time is not accepted. out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-RUN: a=0x1234, b=0x1111, then rst_n=0 for one edge at the 2nd RUN cycle → out_valid=0, s=0, state IDLE. Next op a=0x0005, b=0x000E, cin=0 → s=0x0013, correct.
- WIDTH=4, DIGIT=4 (single-digit):
  - 1+2+1 → s=0x4, c=0
  - 5+6+0 → s=0xB, c=0
  - 9+A+1 → s=0x4, c=1
  - 5+E+0 → s=0x3, c=1
  - each with 1-cycle latency.
- WIDTH=8, DIGIT=1 (bit-serial): a=0x80, b=0x80, cin=0 → s=0x00, cout=1, ovf=1, latency 8. Back-to-back ops with out_ready tied 1: one result per 10 cycles.
